// File: rtl/ddr2_cmd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr2_cmd_pkg - DDR2 command set, scheduler states, widths and timing. Rev 1.0
// ---------------------------------------------------------------------------
`ifndef DRAM_CS_WIDTH
`define DRAM_CS_WIDTH 2
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

package ddr2_cmd_pkg;

  localparam int DRAM_CS_W   = `DRAM_CS_WIDTH;
  localparam int DRAM_BA_W   = `DRAM_BA_WIDTH;
  localparam int DRAM_ADDR_W = `DRAM_ADDR_WIDTH;
  localparam int A10         = 10;

  localparam int T_REFI_DEF       = 3120;
  localparam int T_RP_DEF         = 5;
  localparam int T_RFC_DEF        = 51;
  localparam int MAX_POSTPONE_DEF = 8;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6,
    CMD_MRS  = 3'd7
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RP_WAIT  = 2'd1,
    ST_RFC_WAIT = 2'd2
  } sched_state_t;

  // Returns {ras_n, cas_n, we_n}; PRE and PREA differ only in A10.
  function automatic logic [2:0] cmd_encode(input cmd_t cmd);
    logic [2:0] rcw;
    case (cmd)
      CMD_ACT:  rcw = 3'b011;
      CMD_RD:   rcw = 3'b101;
      CMD_WR:   rcw = 3'b100;
      CMD_PRE:  rcw = 3'b010;
      CMD_PREA: rcw = 3'b010;
      CMD_REF:  rcw = 3'b001;
      CMD_MRS:  rcw = 3'b000;
      default:  rcw = 3'b111;
    endcase
    return rcw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dfi_cmd_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dfi_cmd_sched_if - requester handshake and DFI control bus bundle. Rev 1.0
// ---------------------------------------------------------------------------
interface dfi_cmd_sched_if;
  import ddr2_cmd_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  cmd_t                   req_cmd;
  logic [DRAM_CS_W-1:0]   req_cs;
  logic [DRAM_BA_W-1:0]   req_ba;
  logic [DRAM_ADDR_W-1:0] req_addr;
  logic                   req_odt;

  logic                   dfi_cke;
  logic [DRAM_CS_W-1:0]   dfi_cs_n;
  logic                   dfi_ras_n;
  logic                   dfi_cas_n;
  logic                   dfi_we_n;
  logic [DRAM_BA_W-1:0]   dfi_ba;
  logic [DRAM_ADDR_W-1:0] dfi_addr;
  logic                   dfi_odt;

  modport master (
    output req_valid, req_cmd, req_cs, req_ba, req_addr, req_odt,
    input  req_ready,
    input  dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba, dfi_addr, dfi_odt
  );

  modport slave (
    input  req_valid, req_cmd, req_cs, req_ba, req_addr, req_odt,
    output req_ready,
    output dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba, dfi_addr, dfi_odt
  );

endinterface
`default_nettype wire

// File: rtl/ddr2_refresh_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr2_refresh_timer - tREFI tick generator and postponed-refresh counter. Rev 1.0
// ---------------------------------------------------------------------------
module ddr2_refresh_timer
  import ddr2_cmd_pkg::*;
#(
  parameter int T_REFI       = T_REFI_DEF,
  parameter int MAX_POSTPONE = MAX_POSTPONE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_done_i,
  input  logic       ref_issue_i,
  output logic [3:0] ref_pending_o,
  output logic       ref_overflow_o
);

  localparam int REFI_W = (T_REFI > 1) ? $clog2(T_REFI) : 1;

  logic [REFI_W-1:0] refi_cnt_q, refi_cnt_d;
  logic [3:0]        pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              tick;

  always_comb begin
    tick       = 1'b0;
    refi_cnt_d = '0;
    if (init_done_i) begin
      if (refi_cnt_q == REFI_W'(T_REFI - 1)) begin
        tick = 1'b1;
      end else begin
        refi_cnt_d = refi_cnt_q + 1'b1;
      end
    end
  end

  // A tick coinciding with a REF cancels out, so it can never overflow.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (tick && !ref_issue_i) begin
      if (pending_q == 4'(MAX_POSTPONE)) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 4'd1;
      end
    end else if (!tick && ref_issue_i) begin
      pending_d = pending_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refi_cnt_q <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      refi_cnt_q <= refi_cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign ref_pending_o  = pending_q;
  assign ref_overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: rtl/dfi_cmd_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dfi_cmd_sched - arbitrates requester commands against refresh onto DFI. Rev 1.0
// ---------------------------------------------------------------------------
module dfi_cmd_sched
  import ddr2_cmd_pkg::*;
#(
  parameter int T_REFI       = T_REFI_DEF,
  parameter int T_RP         = T_RP_DEF,
  parameter int T_RFC        = T_RFC_DEF,
  parameter int MAX_POSTPONE = MAX_POSTPONE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init_done_i,
  input  logic            init_cke_i,
  dfi_cmd_sched_if.slave  bus,
  output logic            ref_busy_o,
  output logic [3:0]      ref_pending_o,
  output logic            ref_overflow_o
);

  localparam int WAIT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  sched_state_t           state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   cke_q;
  logic [DRAM_CS_W-1:0]   cs_n_q, cs_n_d;
  logic [2:0]             rcw_q, rcw_d;
  logic [DRAM_BA_W-1:0]   ba_q, ba_d;
  logic [DRAM_ADDR_W-1:0] addr_q, addr_d;
  logic                   odt_q, odt_d;
  logic                   ref_issue;
  logic                   req_ready;
  logic [3:0]             pending;

  ddr2_refresh_timer #(
    .T_REFI       (T_REFI),
    .MAX_POSTPONE (MAX_POSTPONE)
  ) u_refresh_timer (
    .clk            (clk),
    .rst            (rst),
    .init_done_i    (init_done_i),
    .ref_issue_i    (ref_issue),
    .ref_pending_o  (pending),
    .ref_overflow_o (ref_overflow_o)
  );

  assign req_ready = (state_q == ST_IDLE) && (pending < 4'(MAX_POSTPONE));

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    ref_issue = 1'b0;
    cs_n_d    = '1;
    rcw_d     = 3'b111;
    ba_d      = ba_q;
    addr_d    = addr_q;
    odt_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready) begin
          cs_n_d = ~bus.req_cs;
          rcw_d  = cmd_encode(bus.req_cmd);
          ba_d   = bus.req_ba;
          addr_d = bus.req_addr;
          odt_d  = bus.req_odt;
          if (bus.req_cmd == CMD_PRE) begin
            addr_d[A10] = 1'b0;
          end else if (bus.req_cmd == CMD_PREA) begin
            addr_d[A10] = 1'b1;
          end
        end else if (pending != 4'd0) begin
          cs_n_d      = '0;
          rcw_d       = cmd_encode(CMD_PREA);
          ba_d        = '0;
          addr_d      = '0;
          addr_d[A10] = 1'b1;
          wait_d      = WAIT_W'(T_RP - 1);
          state_d     = ST_RP_WAIT;
        end
      end
      ST_RP_WAIT: begin
        if (wait_q == '0) begin
          cs_n_d    = '0;
          rcw_d     = cmd_encode(CMD_REF);
          ref_issue = 1'b1;
          wait_d    = WAIT_W'(T_RFC - 1);
          state_d   = ST_RFC_WAIT;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_RFC_WAIT: begin
        // Leave one count early: the IDLE decision cycle is the last tRFC cycle.
        if (wait_q <= WAIT_W'(1)) begin
          wait_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      cke_q   <= 1'b0;
      cs_n_q  <= '1;
      rcw_q   <= 3'b111;
      ba_q    <= '0;
      addr_q  <= '0;
      odt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cke_q   <= init_cke_i;
      cs_n_q  <= cs_n_d;
      rcw_q   <= rcw_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      odt_q   <= odt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.dfi_cke   = cke_q;
  assign bus.dfi_cs_n  = cs_n_q;
  assign bus.dfi_ras_n = rcw_q[2];
  assign bus.dfi_cas_n = rcw_q[1];
  assign bus.dfi_we_n  = rcw_q[0];
  assign bus.dfi_ba    = ba_q;
  assign bus.dfi_addr  = addr_q;
  assign bus.dfi_odt   = odt_q;

  assign ref_busy_o    = (state_q != ST_IDLE);
  assign ref_pending_o = pending;

endmodule
`default_nettype wire

// File: tb/tb_dfi_cmd_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dfi_cmd_sched - random stimulus checked against a timestamp refresh model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_dfi_cmd_sched;
  import ddr2_cmd_pkg::*;

  localparam int CS_W      = DRAM_CS_W;
  localparam int BA_W      = DRAM_BA_W;
  localparam int AD_W      = DRAM_ADDR_W;
  localparam int TB_REFI_A = 20;
  localparam int TB_REFI_B = 4;
  localparam int TB_RP     = 3;
  localparam int TB_RFC    = 8;
  localparam int TB_MAX    = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            init_done = 1'b0;
  logic            init_cke = 1'b0;
  logic            req_valid = 1'b0;
  cmd_t            req_cmd = CMD_NOP;
  logic [CS_W-1:0] req_cs = '0;
  logic [BA_W-1:0] req_ba = '0;
  logic [AD_W-1:0] req_addr = '0;
  logic            req_odt = 1'b0;

  logic       busy_a, ovf_a, busy_b, ovf_b;
  logic [3:0] pend_a, pend_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit sel_b = 1'b0;

  // Reference model: refresh sequences are tracked as absolute cycle stamps.
  int m_refi, m_timer, m_pend, m_dec_at, m_ref_at, m_free_at;
  bit m_ovf;
  logic            e_cke, e_odt;
  logic [CS_W-1:0] e_cs_n;
  logic [2:0]      e_rcw;
  logic [BA_W-1:0] e_ba;
  logic [AD_W-1:0] e_addr;
  logic [2:0]      enc_tab [8];

  always #5 clk = ~clk;

  dfi_cmd_sched_if ifa ();
  dfi_cmd_sched_if ifb ();

  assign ifa.req_valid = req_valid;
  assign ifa.req_cmd   = req_cmd;
  assign ifa.req_cs    = req_cs;
  assign ifa.req_ba    = req_ba;
  assign ifa.req_addr  = req_addr;
  assign ifa.req_odt   = req_odt;
  assign ifb.req_valid = req_valid;
  assign ifb.req_cmd   = req_cmd;
  assign ifb.req_cs    = req_cs;
  assign ifb.req_ba    = req_ba;
  assign ifb.req_addr  = req_addr;
  assign ifb.req_odt   = req_odt;

  dfi_cmd_sched #(
    .T_REFI(TB_REFI_A), .T_RP(TB_RP), .T_RFC(TB_RFC), .MAX_POSTPONE(TB_MAX)
  ) u_dut_a (
    .clk(clk), .rst(rst), .init_done_i(init_done), .init_cke_i(init_cke),
    .bus(ifa), .ref_busy_o(busy_a), .ref_pending_o(pend_a), .ref_overflow_o(ovf_a)
  );

  dfi_cmd_sched #(
    .T_REFI(TB_REFI_B), .T_RP(TB_RP), .T_RFC(TB_RFC), .MAX_POSTPONE(TB_MAX)
  ) u_dut_b (
    .clk(clk), .rst(rst), .init_done_i(init_done), .init_cke_i(init_cke),
    .bus(ifb), .ref_busy_o(busy_b), .ref_pending_o(pend_b), .ref_overflow_o(ovf_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit in_seq();
    return (cyc > m_dec_at) && (cyc < m_free_at);
  endfunction

  task automatic model_reset();
    m_timer   = 0;
    m_pend    = 0;
    m_ovf     = 1'b0;
    m_dec_at  = -1000;
    m_ref_at  = -1000;
    m_free_at = -1000;
    e_cke     = 1'b0;
    e_cs_n    = '1;
    e_rcw     = 3'b111;
    e_ba      = '0;
    e_addr    = '0;
    e_odt     = 1'b0;
  endtask

  task automatic check_outputs(input string p);
    logic rdy, bsy, ovf, cke, odt, ras, cas, we;
    logic [3:0] pnd;
    logic [CS_W-1:0] csn;
    logic [BA_W-1:0] ba;
    logic [AD_W-1:0] ad;
    if (sel_b) begin
      rdy = ifb.req_ready; bsy = busy_b; ovf = ovf_b; pnd = pend_b; cke = ifb.dfi_cke;
      csn = ifb.dfi_cs_n; ras = ifb.dfi_ras_n; cas = ifb.dfi_cas_n; we = ifb.dfi_we_n;
      ba = ifb.dfi_ba; ad = ifb.dfi_addr; odt = ifb.dfi_odt;
    end else begin
      rdy = ifa.req_ready; bsy = busy_a; ovf = ovf_a; pnd = pend_a; cke = ifa.dfi_cke;
      csn = ifa.dfi_cs_n; ras = ifa.dfi_ras_n; cas = ifa.dfi_cas_n; we = ifa.dfi_we_n;
      ba = ifa.dfi_ba; ad = ifa.dfi_addr; odt = ifa.dfi_odt;
    end
    check_val({p, "ready"},    32'(rdy), 32'(!in_seq() && (m_pend < TB_MAX)));
    check_val({p, "busy"},     32'(bsy), 32'(in_seq()));
    check_val({p, "pending"},  32'(pnd), 32'(m_pend));
    check_val({p, "overflow"}, 32'(ovf), 32'(m_ovf));
    check_val({p, "cke"},      32'(cke), 32'(e_cke));
    check_val({p, "cs_n"},     32'(csn), 32'(e_cs_n));
    check_val({p, "ras_cas_we"}, 32'({ras, cas, we}), 32'(e_rcw));
    check_val({p, "ba"},       32'(ba),  32'(e_ba));
    check_val({p, "addr"},     32'(ad),  32'(e_addr));
    check_val({p, "odt"},      32'(odt), 32'(e_odt));
  endtask

  // Predict what this cycle's inputs put on DFI next cycle and the counters.
  task automatic model_step();
    bit tick, issue;
    issue  = 1'b0;
    e_cs_n = '1;
    e_rcw  = 3'b111;
    e_odt  = 1'b0;
    if (!in_seq()) begin
      if (req_valid && (m_pend < TB_MAX)) begin
        e_cs_n = ~req_cs;
        e_rcw  = enc_tab[req_cmd];
        e_ba   = req_ba;
        e_addr = req_addr;
        e_odt  = req_odt;
        if (req_cmd == CMD_PRE)  e_addr[10] = 1'b0;
        if (req_cmd == CMD_PREA) e_addr[10] = 1'b1;
      end else if (m_pend > 0) begin
        e_cs_n    = '0;
        e_rcw     = 3'b010;
        e_ba      = '0;
        e_addr    = AD_W'(1) << 10;
        m_dec_at  = cyc;
        m_ref_at  = cyc + TB_RP;
        m_free_at = cyc + TB_RP + TB_RFC;
      end
    end else if (cyc == m_ref_at) begin
      e_cs_n = '0;
      e_rcw  = 3'b001;
      issue  = 1'b1;
    end
    e_cke   = init_cke;
    tick    = init_done && (m_timer == m_refi - 1);
    m_timer = init_done ? (m_timer + 1) % m_refi : 0;
    m_pend  = m_pend + (tick ? 1 : 0) - (issue ? 1 : 0);
    if (m_pend > TB_MAX) begin
      m_pend = TB_MAX;
      m_ovf  = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs("");
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_stim(input int pct_valid);
    req_valid = ($urandom_range(99) < pct_valid);
    req_cmd   = cmd_t'($urandom_range(7));
    req_cs    = CS_W'(1) << $urandom_range(CS_W - 1);
    req_ba    = BA_W'($urandom);
    req_addr  = AD_W'($urandom);
    req_odt   = 1'($urandom);
    init_cke  = ($urandom_range(9) != 0);
  endtask

  // Called just after a rising edge; checks the asynchronous response before any edge.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc++;
  endtask

  initial begin
    enc_tab = '{3'b111, 3'b011, 3'b101, 3'b100, 3'b010, 3'b010, 3'b001, 3'b000};
    m_refi  = TB_REFI_A;
    apply_reset();

    for (int i = 0; i < 6; i++) begin
      init_cke = (i >= 3);
      step();
    end

    req_valid = 1'b1; req_cmd = CMD_ACT; req_cs = CS_W'(1);
    req_ba = BA_W'(2); req_addr = AD_W'('h1A3); req_odt = 1'b0; init_cke = 1'b1;
    step();
    rand_stim(0);
    step();

    for (int i = 0; i < 30; i++) begin rand_stim(50); step(); end

    init_done = 1'b1;
    for (int i = 0; i < 45; i++) begin rand_stim(0); step(); end
    for (int i = 0; i < 200; i++) begin rand_stim(100); step(); end
    for (int i = 0; i < 60; i++) begin rand_stim(50); step(); end

    begin
      bit reached;
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
        rand_stim(0);
        step();
        if ((cyc > m_ref_at + 2) && (cyc < m_free_at)) reached = 1'b1;
      end
      check_val("reach_rfc_wait", 32'(reached), 32'd1);
    end
    apply_reset();
    for (int i = 0; i < 10; i++) begin rand_stim(50); step(); end

    sel_b  = 1'b1;
    m_refi = TB_REFI_B;
    apply_reset();
    for (int i = 0; i < 120; i++) begin rand_stim(70); step(); end
    check_val("overflow_sticky", 32'(ovf_b), 32'd1);
    apply_reset();
    for (int i = 0; i < 5; i++) begin rand_stim(50); step(); end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
